maf_t4_add_norm: RTL and testbench



---
 rtl/maf_pkg.sv | 27 ++
 rtl/maf_lzc74.sv | 17 +
 rtl/maf_t4_add_norm.sv | 148 ++++++++++++++
 tb/tb_maf_t4_add_norm.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maf_pkg.sv
// Shared constants and stage-beat types for the MAF datapath.
// Optional range flags in the add/normalize stage: MAF_T4_RANGE_FLAGS_EN.
package maf_pkg;

  localparam int W_ACC   = 74;
  localparam int W_PROD  = 48;
  localparam int W_EXP   = 12;
  localparam int EXP_MAX = 254;
  localparam int W_LZC   = 7;

  typedef enum logic [3:0] {
    TRAP_NONE = 4'h0,
    TRAP_INV  = 4'h1,
    TRAP_DZ   = 4'h2,
    TRAP_INF  = 4'h4,
    TRAP_NAN  = 4'h8
  } trap_e;

  typedef struct packed {
    logic [W_ACC-1:0] mag;
    logic             sign;
    logic [W_EXP-1:0] exp;
    logic [3:0]       trap;
    logic [2:0]       trap_ans;
  } beat_t;

endpackage

// File: rtl/maf_lzc74.sv
// Combinational leading-zero counter for the 74-bit magnitude.
// All-zero input yields a count of 74.
module maf_lzc74
  import maf_pkg::*;
(
  input  logic [W_ACC-1:0] data,
  output logic [W_LZC-1:0] count
);

  always_comb begin
    count = W_LZC'(W_ACC);
    for (int i = 0; i < W_ACC; i++) begin
      if (data[i]) count = W_LZC'(W_ACC - 1 - i);
    end
  end

endmodule

// File: rtl/maf_t4_add_norm.sv
// MAF stage 4: carry-propagate add/sub, sign-magnitude, LZC, normalize.
// Define MAF_T4_RANGE_FLAGS_EN to build the registered ovf/unf flags.
module maf_t4_add_norm
  import maf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_PROD-1:0] sum_in,
  input  logic [W_PROD-1:0] carry_in,
  input  logic [W_ACC-1:0]  addend_in,
  input  logic              eff_sub,
  input  logic              sign_in,
  input  logic [W_EXP-1:0]  exp_in,
  input  logic [3:0]        trap_in,
  input  logic [2:0]        trap_ans_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       mant_out,
  output logic              guard_out,
  output logic              round_out,
  output logic              sticky_out,
  output logic [W_EXP-1:0]  exp_out,
  output logic              sign_out,
  output logic              zero_out,
  output logic [3:0]        trap_out,
  output logic [2:0]        trap_ans_out,
  output logic              ovf_out,
  output logic              unf_out
);

  localparam int W_PAD = W_ACC + 1 - W_PROD;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [W_PROD-1:0] prod;
  logic [W_ACC:0]    raw;
  logic [W_ACC-1:0]  low;
  logic              neg;
  beat_t             s1_d;
  beat_t             s1_q;

  always_comb begin
    prod = sum_in + carry_in;
    if (eff_sub)
      raw = {1'b0, addend_in} - {{W_PAD{1'b0}}, prod};
    else
      raw = {1'b0, addend_in} + {{W_PAD{1'b0}}, prod};
    low = raw[W_ACC-1:0];
    // Only a subtraction can go negative; the add's carry is dropped.
    neg = eff_sub && raw[W_ACC];
    s1_d.mag      = neg ? -low : low;
    s1_d.sign     = sign_in ^ neg;
    s1_d.exp      = exp_in;
    s1_d.trap     = trap_in;
    s1_d.trap_ans = trap_ans_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [W_LZC-1:0] lzc;
  logic [W_ACC-1:0] norm;
  logic             zero_n;
  logic [W_EXP-1:0] exp_n;

  maf_lzc74 u_lzc (
    .data  (s1_q.mag),
    .count (lzc)
  );

  always_comb begin
    norm   = s1_q.mag << lzc;
    zero_n = (lzc == W_LZC'(W_ACC));
    exp_n  = zero_n ? '0 : s1_q.exp - W_EXP'(lzc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      mant_out     <= '0;
      guard_out    <= 1'b0;
      round_out    <= 1'b0;
      sticky_out   <= 1'b0;
      exp_out      <= '0;
      sign_out     <= 1'b0;
      zero_out     <= 1'b0;
      trap_out     <= '0;
      trap_ans_out <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        mant_out     <= norm[73:50];
        guard_out    <= norm[49];
        round_out    <= norm[48];
        sticky_out   <= |norm[47:0];
        exp_out      <= exp_n;
        sign_out     <= s1_q.sign && !zero_n;
        zero_out     <= zero_n;
        trap_out     <= s1_q.trap;
        trap_ans_out <= s1_q.trap_ans;
      end
    end
  end

`ifdef MAF_T4_RANGE_FLAGS_EN
  localparam logic signed [W_EXP-1:0] EMAX = W_EXP'(EXP_MAX);
  localparam logic signed [W_EXP-1:0] EMIN = W_EXP'(1);

  logic ovf_n;
  logic unf_n;

  always_comb begin
    ovf_n = !zero_n && ($signed(exp_n) > EMAX);
    unf_n = !zero_n && ($signed(exp_n) < EMIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_out <= 1'b0;
      unf_out <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      ovf_out <= ovf_n;
      unf_out <= unf_n;
    end
  end
`else
  assign ovf_out = 1'b0;
  assign unf_out = 1'b0;
`endif

endmodule

// File: tb/tb_maf_t4_add_norm.sv
// Scoreboard bench for maf_t4_add_norm: random and directed beats
// checked against an arithmetic reference model.
module tb_maf_t4_add_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] sum_in = '0;
  logic [47:0] carry_in = '0;
  logic [73:0] addend_in = '0;
  logic        eff_sub = 1'b0;
  logic        sign_in = 1'b0;
  logic [11:0] exp_in = '0;
  logic [3:0]  trap_in = '0;
  logic [2:0]  trap_ans_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] mant_out;
  logic        guard_out, round_out, sticky_out;
  logic [11:0] exp_out;
  logic        sign_out, zero_out;
  logic [3:0]  trap_out;
  logic [2:0]  trap_ans_out;
  logic        ovf_out, unf_out;

  maf_t4_add_norm dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .carry_in(carry_in),
    .addend_in(addend_in), .eff_sub(eff_sub),
    .sign_in(sign_in), .exp_in(exp_in),
    .trap_in(trap_in), .trap_ans_in(trap_ans_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .guard_out(guard_out),
    .round_out(round_out), .sticky_out(sticky_out),
    .exp_out(exp_out), .sign_out(sign_out),
    .zero_out(zero_out), .trap_out(trap_out),
    .trap_ans_out(trap_ans_out),
    .ovf_out(ovf_out), .unf_out(unf_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit rnd_mode = 1'b0;
  logic [49:0] q[$];

  wire [49:0] act = {mant_out, guard_out, round_out, sticky_out,
                     exp_out, sign_out, zero_out, trap_out,
                     trap_ans_out, ovf_out, unf_out};

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  // Reference: plain integer arithmetic, shift-until-msb normalize.
  function automatic logic [49:0] model(
    input logic [47:0] s, input logic [47:0] c,
    input logic [73:0] a, input logic es, input logic sg,
    input logic [11:0] e, input logic [3:0] t, input logic [2:0] ta);
    logic [47:0] p;
    logic [73:0] m;
    logic        rs;
    logic [11:0] eo;
    int          lz;
    logic        ov, un;
    p  = s + c;
    rs = sg;
    if (!es) m = a + {26'b0, p};
    else if (a >= {26'b0, p}) m = a - {26'b0, p};
    else begin
      m  = {26'b0, p} - a;
      rs = !sg;
    end
    if (m == 0)
      return {24'b0, 3'b0, 12'b0, 1'b0, 1'b1, t, ta, 2'b0};
    lz = 0;
    while (!m[73]) begin
      m = m << 1;
      lz++;
    end
    eo = e - 12'(lz);
    ov = 1'b0;
    un = 1'b0;
`ifdef MAF_T4_RANGE_FLAGS_EN
    ov = $signed(eo) > 12'sd254;
    un = $signed(eo) < 12'sd1;
`endif
    return {m[73:50], m[49], m[48], |m[47:0], eo, rs, 1'b0,
            t, ta, ov, un};
  endfunction

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready)
      q.push_back(model(sum_in, carry_in, addend_in, eff_sub,
                        sign_in, exp_in, trap_in, trap_ans_in));
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL scoreboard_underflow: got beat %h expected none",
                 act);
      end else begin
        chk("beat", 64'(act), 64'(q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] s, input logic [47:0] c,
                      input logic [73:0] a, input logic es,
                      input logic sg, input logic [11:0] e,
                      input logic [3:0] t, input logic [2:0] ta);
    bit done;
    done = 1'b0;
    sum_in = s; carry_in = c; addend_in = a; eff_sub = es;
    sign_in = sg; exp_in = e; trap_in = t; trap_ans_in = ta;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic expect_out(input string nm, input logic [23:0] m,
                            input logic [2:0] grs, input logic [11:0] e,
                            input logic sg, input logic z);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s_timeout: got out_valid 0 expected 1", nm);
    end else begin
      chk(nm, {mant_out, guard_out, round_out, sticky_out, exp_out,
               sign_out, zero_out}, {m, grs, e, sg, z});
    end
    tick();
  endtask

  initial begin
    logic [73:0] big;
    logic [95:0] r;
    logic [47:0] s, c;
    logic [73:0] a;
    big = 74'b1 << 73;

    repeat (2) tick();
    @(negedge clk);
    chk("reset_outputs", 64'({out_valid, act}), 64'(0));
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'(1));
    tick();

    send(48'd1, 48'd0, big, 1'b0, 1'b0, 12'd130, 4'h0, 3'd0);
    expect_out("vec_big", 24'h800000, 3'b001, 12'd130, 1'b0, 1'b0);
    send(48'd3, 48'd2, 74'd5, 1'b1, 1'b1, 12'd77, 4'h2, 3'd5);
    expect_out("vec_zero", 24'h0, 3'b000, 12'd0, 1'b0, 1'b1);
    send(48'd4, 48'd0, 74'd1, 1'b1, 1'b0, 12'd100, 4'h0, 3'd0);
    expect_out("vec_neg", 24'hC00000, 3'b000, 12'd28, 1'b1, 1'b0);
    send(48'd0, 48'd0, big, 1'b0, 1'b0, 12'd300, 4'h8, 3'd1);
    send(48'd0, 48'd0, 74'b1 << 63, 1'b0, 1'b0, 12'd5, 4'h0, 3'd2);
    repeat (4) tick();
`ifdef MAF_T4_RANGE_FLAGS_EN
    send(48'd0, 48'd0, big, 1'b0, 1'b0, 12'd300, 4'h0, 3'd0);
    expect_out("ovf_mant", 24'h800000, 3'b000, 12'd300, 1'b0, 1'b0);
    chk("ovf_flag", 64'({ovf_out, unf_out}), 64'(2'b10));
`endif

    // Stall: two beats fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(48'd1, 48'd0, big, 1'b0, 1'b0, 12'd130, 4'h1, 3'd1);
    send(48'd3, 48'd2, 74'd5, 1'b1, 1'b1, 12'd9, 4'h2, 3'd2);
    in_valid = 1'b1;
    sum_in = 48'd4; carry_in = 48'd0; addend_in = 74'd1;
    eff_sub = 1'b1; sign_in = 1'b0; exp_in = 12'd100;
    trap_in = 4'h4; trap_ans_in = 3'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_hold", 64'({out_valid, mant_out, exp_out, trap_out}),
          64'({1'b1, 24'h800000, 12'd130, 4'h1}));
      tick();
    end
    out_ready = 1'b1;
    send(48'd4, 48'd0, 74'd1, 1'b1, 1'b0, 12'd100, 4'h4, 3'd3);
    repeat (4) tick();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(48'd7, 48'd1, 74'd99, 1'b0, 1'b1, 12'd50, 4'h1, 3'd1);
    send(48'd9, 48'd1, 74'd12345, 1'b0, 1'b1, 12'd60, 4'h2, 3'd2);
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("flush_outputs", 64'({out_valid, act}), 64'(0));
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      @(negedge clk);
      chk("flush_no_stale", 64'(out_valid), 64'(0));
    end
    tick();

    rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = {$urandom, $urandom, $urandom};
      s = {$urandom, $urandom};
      c = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) c = '0;
      a = r[73:0] >> $urandom_range(0, 80);
      if ($urandom_range(0, 7) == 0) a = {26'b0, s + c};
      send(s, c, a, 1'($urandom), 1'($urandom), 12'($urandom),
           4'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_mode = 1'b0;
    #2 out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) tick();
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
